// File: rtl/serdes_window.sv
// Word serialiser/deserialiser between a W-bit stream and a W*N-bit caller-owned buffer, windowed to K of N words.
// Latency: buffer_write and ser are combinational from the inputs; one word per cycle; a new command is taken the cycle after the last step.
// Backpressure: des is held off by des_canReceive, and ser by ser_canReceive; commands arriving while busy are ignored, not queued.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   cmd_startDes/Ser         command request bits, accepted when cmd_canReceive=1
//   cmd_numWords             window length K (0 or >N means N), sampled at accept
//   cmd_canReceive           idle; a command is accepted this cycle
//   buffer_read/write        current buffer value / next buffer value (caller registers)
//   des, des_isReady         incoming word and its valid
//   des_canReceive           incoming word is consumed this cycle
//   des_isLast, ser_isLast   this step is the last one of the window
//   ser, ser_isReady         outgoing word (buffer word 0) and its valid
//   ser_canReceive           sink accepts ser
module serdes_window #(
   parameter int W = 64,
   parameter int N = 4,
   localparam int LW = $clog2(N + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_startDes,
   input  logic            cmd_startSer,
   input  logic [LW-1:0]   cmd_numWords,
   output logic            cmd_canReceive,
   output logic [W*N-1:0]  buffer_write,
   input  logic [W*N-1:0]  buffer_read,
   input  logic [W-1:0]    des,
   input  logic            des_isReady,
   output logic            des_canReceive,
   output logic            des_isLast,
   output logic [W-1:0]    ser,
   output logic            ser_isReady,
   input  logic            ser_canReceive,
   output logic            ser_isLast
);

   localparam logic [LW-1:0] N_W = LW'(N);

   logic [LW-1:0] rem_q;
   logic [LW-1:0] win_q;
   logic          is_ser_q;
   logic          is_des_q;

   logic          start;
   logic [LW-1:0] k_cmd;
   logic [LW-1:0] rem_eff;
   logic [LW-1:0] win_eff;
   logic          ser_eff;
   logic          des_eff;
   logic          busy;
   logic          step;
   logic [W-1:0]  in_word;
   logic [W*(N+1)-1:0] ext;

   assign cmd_canReceive = (rem_q == '0);

   // Reset gates acceptance so nothing steps while rst is held low.
   assign start = rst & cmd_canReceive & (cmd_startSer | cmd_startDes);

   // Zero or out-of-range lengths mean a full-depth window.
   assign k_cmd = ((cmd_numWords == '0) || (cmd_numWords > N_W)) ? N_W : cmd_numWords;

   // The accept cycle already runs with the new command's settings.
   assign rem_eff = start ? k_cmd        : rem_q;
   assign win_eff = start ? k_cmd        : win_q;
   assign ser_eff = start ? cmd_startSer : is_ser_q;
   assign des_eff = start ? cmd_startDes : is_des_q;
   assign busy    = (rem_eff != '0);

   // In both-modes operation a word moves only when the source and the sink are both ready.
   assign step = busy & (des_eff ? (des_isReady & (ser_eff ? ser_canReceive : 1'b1))
                                 : ser_canReceive);

   assign des_canReceive = des_eff & busy & (ser_eff ? ser_canReceive : 1'b1);
   assign ser_isReady    = ser_eff & busy & (des_eff ? des_isReady : ser_canReceive);
   assign des_isLast     = step & (rem_eff == LW'(1));
   assign ser_isLast     = des_isLast;
   assign ser            = buffer_read[W-1:0];

   // Word entering the top of the window: new des word, or the old word 0 for a pure rotate.
   assign in_word = des_eff ? des : buffer_read[W-1:0];
   // One spare word above the buffer keeps the shift indexing in range for every i.
   assign ext     = {in_word, buffer_read};

   always_comb begin
      buffer_write = buffer_read;
      if (step) begin
         for (int i = 0; i < N; i++) begin
            if (i + 1 < int'(win_eff))
               buffer_write[i*W +: W] = ext[(i+1)*W +: W];
            else if (i + 1 == int'(win_eff))
               buffer_write[i*W +: W] = in_word;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q    <= '0;
         win_q    <= '0;
         is_ser_q <= 1'b0;
         is_des_q <= 1'b0;
      end else begin
         rem_q <= step ? (rem_eff - LW'(1)) : rem_eff;
         if (start) begin
            win_q    <= k_cmd;
            is_ser_q <= cmd_startSer;
            is_des_q <= cmd_startDes;
         end
      end
   end

endmodule

// File: tb/tb_serdes_window.sv
module tb_serdes_window;

   localparam int W  = 64;
   localparam int N  = 4;
   localparam int LW = 3;

   localparam logic [63:0] A  = 64'hA0A0_0000_0000_00A1;
   localparam logic [63:0] B  = 64'hB0B0_0000_0000_00B2;
   localparam logic [63:0] C  = 64'hC0C0_0000_0000_00C3;
   localparam logic [63:0] D  = 64'hD0D0_0000_0000_00D4;
   localparam logic [63:0] P  = 64'h1111_2222_3333_4444;
   localparam logic [63:0] Q  = 64'h5555_6666_7777_8888;
   localparam logic [63:0] R  = 64'h9999_AAAA_BBBB_CCCC;
   localparam logic [63:0] W0 = 64'h0000_0000_0000_F000;
   localparam logic [63:0] W1 = 64'h0000_0000_0000_F001;
   localparam logic [63:0] W2 = 64'h0000_0000_0000_F002;
   localparam logic [63:0] W3 = 64'h0000_0000_0000_F003;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Main instance W=64, N=4
   logic          cmd_startDes, cmd_startSer, cmd_canReceive;
   logic [LW-1:0] cmd_numWords;
   logic [W*N-1:0] bw, buf_q, ld_val;
   logic          ld;
   logic [W-1:0]  des, ser;
   logic          des_isReady, des_canReceive, des_isLast;
   logic          ser_isReady, ser_canReceive, ser_isLast;

   // Narrow instance W=8, N=1
   logic          c8_startDes, c8_startSer, c8_canReceive;
   logic [0:0]    c8_numWords;
   logic [7:0]    bw8, buf8_q, ld8_val;
   logic          ld8;
   logic [7:0]    des8, ser8;
   logic          des8_isReady, des8_canReceive, des8_isLast;
   logic          ser8_isReady, ser8_canReceive, ser8_isLast;

   int n_checks = 0;
   int n_fail   = 0;

   // Caller-owned buffer registers
   always @(posedge clk) buf_q  <= ld  ? ld_val  : bw;
   always @(posedge clk) buf8_q <= ld8 ? ld8_val : bw8;

   serdes_window #(.W(W), .N(N)) dut (
      .clk(clk), .rst(rst),
      .cmd_startDes(cmd_startDes), .cmd_startSer(cmd_startSer),
      .cmd_numWords(cmd_numWords), .cmd_canReceive(cmd_canReceive),
      .buffer_write(bw), .buffer_read(buf_q),
      .des(des), .des_isReady(des_isReady), .des_canReceive(des_canReceive),
      .des_isLast(des_isLast),
      .ser(ser), .ser_isReady(ser_isReady), .ser_canReceive(ser_canReceive),
      .ser_isLast(ser_isLast)
   );

   serdes_window #(.W(8), .N(1)) dut8 (
      .clk(clk), .rst(rst),
      .cmd_startDes(c8_startDes), .cmd_startSer(c8_startSer),
      .cmd_numWords(c8_numWords), .cmd_canReceive(c8_canReceive),
      .buffer_write(bw8), .buffer_read(buf8_q),
      .des(des8), .des_isReady(des8_isReady), .des_canReceive(des8_canReceive),
      .des_isLast(des8_isLast),
      .ser(ser8), .ser_isReady(ser8_isReady), .ser_canReceive(ser8_canReceive),
      .ser_isLast(ser8_isLast)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      cmd_startDes = 0; cmd_startSer = 0; cmd_numWords = '0;
      des = '0; des_isReady = 0; ser_canReceive = 0; ld = 0; ld_val = '0;
      c8_startDes = 0; c8_startSer = 0; c8_numWords = '0;
      des8 = '0; des8_isReady = 0; ser8_canReceive = 0; ld8 = 0; ld8_val = '0;
   endtask

   task automatic test_reset;
      // Buffer gets a known value while reset is held; request attempts must be ignored.
      ld = 1; ld_val = {W3, W2, W1, W0}; ld8 = 1; ld8_val = 8'h5A;
      tick;
      ld = 0; ld8 = 0;
      cmd_startDes = 1; cmd_numWords = 3; des = P; des_isReady = 1; ser_canReceive = 1;
      #4;
      n_checks++; if (cmd_canReceive !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_canReceive got %0b want 1", cmd_canReceive); end
      n_checks++; if (des_canReceive !== 1'b0) begin n_fail++; $display("FAIL rst_des_canReceive got %0b want 0", des_canReceive); end
      n_checks++; if (ser_isReady !== 1'b0) begin n_fail++; $display("FAIL rst_ser_isReady got %0b want 0", ser_isReady); end
      n_checks++; if (des_isLast !== 1'b0) begin n_fail++; $display("FAIL rst_des_isLast got %0b want 0", des_isLast); end
      n_checks++; if (bw !== {W3, W2, W1, W0}) begin n_fail++; $display("FAIL rst_buffer_write got %h want %h", bw, {W3, W2, W1, W0}); end
      n_checks++; if (c8_canReceive !== 1'b1) begin n_fail++; $display("FAIL rst_n1_cmd_canReceive got %0b want 1", c8_canReceive); end
      tick;
      n_checks++; if (buf_q !== {W3, W2, W1, W0}) begin n_fail++; $display("FAIL rst_buffer_hold got %h want %h", buf_q, {W3, W2, W1, W0}); end
      idle_inputs();
      rst = 1;
      tick;
   endtask

   task automatic test_abort;
      cmd_startDes = 1; cmd_numWords = 3; des = P; des_isReady = 1;
      tick;
      cmd_startDes = 0; des = Q;
      tick;
      n_checks++; if (buf_q !== {W3, Q, P, W2}) begin n_fail++; $display("FAIL abort_two_steps got %h want %h", buf_q, {W3, Q, P, W2}); end
      // Reset mid-transfer while des keeps offering words.
      rst = 0; des = R;
      #4;
      n_checks++; if (cmd_canReceive !== 1'b1) begin n_fail++; $display("FAIL abort_cmd_canReceive got %0b want 1", cmd_canReceive); end
      n_checks++; if (des_canReceive !== 1'b0) begin n_fail++; $display("FAIL abort_des_canReceive got %0b want 0", des_canReceive); end
      n_checks++; if (bw !== {W3, Q, P, W2}) begin n_fail++; $display("FAIL abort_buffer_write got %h want %h", bw, {W3, Q, P, W2}); end
      tick;
      rst = 1; des_isReady = 1;
      #4;
      n_checks++; if (buf_q !== {W3, Q, P, W2}) begin n_fail++; $display("FAIL abort_buffer_kept got %h want %h", buf_q, {W3, Q, P, W2}); end
      n_checks++; if (des_canReceive !== 1'b0) begin n_fail++; $display("FAIL abort_no_resume got %0b want 0", des_canReceive); end
      n_checks++; if (cmd_canReceive !== 1'b1) begin n_fail++; $display("FAIL abort_idle got %0b want 1", cmd_canReceive); end
      tick;
      idle_inputs();
   endtask

   task automatic test_des_full;
      logic [63:0] words [4];
      words = '{A, B, C, D};
      for (int k = 0; k < 4; k++) begin
         cmd_startDes = (k == 0); cmd_numWords = 4; des = words[k]; des_isReady = 1;
         #4;
         n_checks++; if (des_canReceive !== 1'b1) begin n_fail++; $display("FAIL des_canReceive[%0d] got %0b want 1", k, des_canReceive); end
         n_checks++; if (des_isLast !== (k == 3)) begin n_fail++; $display("FAIL des_isLast[%0d] got %0b want %0b", k, des_isLast, (k == 3)); end
         n_checks++; if (cmd_canReceive !== (k == 0)) begin n_fail++; $display("FAIL des_cmd_canReceive[%0d] got %0b want %0b", k, cmd_canReceive, (k == 0)); end
         tick;
      end
      idle_inputs();
      #4;
      n_checks++; if (buf_q !== {D, C, B, A}) begin n_fail++; $display("FAIL des_buffer got %h want %h", buf_q, {D, C, B, A}); end
      n_checks++; if (cmd_canReceive !== 1'b1) begin n_fail++; $display("FAIL des_done_idle got %0b want 1", cmd_canReceive); end
      tick;
   endtask

   task automatic test_ser_toggle;
      logic        scr  [3];
      logic [63:0] eser [3];
      logic        erdy [3];
      logic        elst [3];
      scr = '{1'b1, 1'b0, 1'b1};
      eser = '{A, B, B};
      erdy = '{1'b1, 1'b0, 1'b1};
      elst = '{1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
         cmd_startSer = (k == 0); cmd_numWords = 2; ser_canReceive = scr[k];
         #4;
         n_checks++; if (ser !== eser[k]) begin n_fail++; $display("FAIL ser_word[%0d] got %h want %h", k, ser, eser[k]); end
         n_checks++; if (ser_isReady !== erdy[k]) begin n_fail++; $display("FAIL ser_isReady[%0d] got %0b want %0b", k, ser_isReady, erdy[k]); end
         n_checks++; if (ser_isLast !== elst[k]) begin n_fail++; $display("FAIL ser_isLast[%0d] got %0b want %0b", k, ser_isLast, elst[k]); end
         tick;
      end
      idle_inputs();
      #4;
      n_checks++; if (buf_q !== {D, C, B, A}) begin n_fail++; $display("FAIL ser_restored got %h want %h", buf_q, {D, C, B, A}); end
      n_checks++; if (cmd_canReceive !== 1'b1) begin n_fail++; $display("FAIL ser_done_idle got %0b want 1", cmd_canReceive); end
      tick;
   endtask

   task automatic test_both;
      logic        scr  [4];
      logic [63:0] dw   [4];
      logic [63:0] eser [4];
      logic        edcr [4];
      logic        elst [4];
      scr  = '{1'b1, 1'b0, 1'b1, 1'b1};
      dw   = '{P, Q, Q, R};
      eser = '{A, B, B, C};
      edcr = '{1'b1, 1'b0, 1'b1, 1'b1};
      elst = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         cmd_startDes = (k == 0); cmd_startSer = (k == 0); cmd_numWords = 3;
         des = dw[k]; des_isReady = 1; ser_canReceive = scr[k];
         #4;
         n_checks++; if (ser !== eser[k]) begin n_fail++; $display("FAIL both_ser[%0d] got %h want %h", k, ser, eser[k]); end
         n_checks++; if (ser_isReady !== 1'b1) begin n_fail++; $display("FAIL both_ser_isReady[%0d] got %0b want 1", k, ser_isReady); end
         n_checks++; if (des_canReceive !== edcr[k]) begin n_fail++; $display("FAIL both_des_canReceive[%0d] got %0b want %0b", k, des_canReceive, edcr[k]); end
         n_checks++; if (des_isLast !== elst[k]) begin n_fail++; $display("FAIL both_isLast[%0d] got %0b want %0b", k, des_isLast, elst[k]); end
         n_checks++; if (bw[255:192] !== D) begin n_fail++; $display("FAIL both_word3[%0d] got %h want %h", k, bw[255:192], D); end
         tick;
      end
      idle_inputs();
      #4;
      n_checks++; if (buf_q !== {D, R, Q, P}) begin n_fail++; $display("FAIL both_buffer got %h want %h", buf_q, {D, R, Q, P}); end
      tick;
   endtask

   task automatic test_clamp;
      logic [63:0] vals [4];
      int steps;
      int last_at;
      vals = '{P, Q, R, W0};
      // Length 0 means full depth; a busy ser request must not be picked up.
      steps = 0; last_at = -1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         cmd_startDes = (cyc == 0); cmd_startSer = (cyc != 0); cmd_numWords = 0;
         des = vals[steps % 4]; des_isReady = 1; ser_canReceive = 1;
         #4;
         n_checks++; if (ser_isReady !== 1'b0) begin n_fail++; $display("FAIL clamp0_ser_isReady[%0d] got %0b want 0", cyc, ser_isReady); end
         if (des_canReceive && des_isReady) steps++;
         if (des_isLast) last_at = steps;
         tick;
         if (last_at >= 0) break;
      end
      idle_inputs();
      #4;
      n_checks++; if (steps !== 4) begin n_fail++; $display("FAIL clamp0_steps got %0d want 4", steps); end
      n_checks++; if (last_at !== 4) begin n_fail++; $display("FAIL clamp0_last_at got %0d want 4", last_at); end
      n_checks++; if (buf_q !== {W0, R, Q, P}) begin n_fail++; $display("FAIL clamp0_buffer got %h want %h", buf_q, {W0, R, Q, P}); end
      tick;
      // Length 7 also means full depth; a busy des request must not be picked up.
      steps = 0; last_at = -1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         cmd_startSer = (cyc == 0); cmd_startDes = (cyc != 0); cmd_numWords = 7;
         des_isReady = 1; ser_canReceive = 1;
         #4;
         n_checks++; if (des_canReceive !== 1'b0) begin n_fail++; $display("FAIL clamp7_des_canReceive[%0d] got %0b want 0", cyc, des_canReceive); end
         n_checks++; if (ser !== vals[steps % 4]) begin n_fail++; $display("FAIL clamp7_ser[%0d] got %h want %h", cyc, ser, vals[steps % 4]); end
         if (ser_isReady && ser_canReceive) steps++;
         if (ser_isLast) last_at = steps;
         tick;
         if (last_at >= 0) break;
      end
      idle_inputs();
      #4;
      n_checks++; if (steps !== 4) begin n_fail++; $display("FAIL clamp7_steps got %0d want 4", steps); end
      n_checks++; if (last_at !== 4) begin n_fail++; $display("FAIL clamp7_last_at got %0d want 4", last_at); end
      n_checks++; if (buf_q !== {W0, R, Q, P}) begin n_fail++; $display("FAIL clamp7_buffer got %h want %h", buf_q, {W0, R, Q, P}); end
      n_checks++; if (cmd_canReceive !== 1'b1) begin n_fail++; $display("FAIL clamp7_idle got %0b want 1", cmd_canReceive); end
      tick;
   endtask

   task automatic test_narrow;
      c8_startDes = 1; c8_numWords = 1; des8 = 8'hC3; des8_isReady = 1; ser8_canReceive = 1;
      #4;
      n_checks++; if (des8_isLast !== 1'b1) begin n_fail++; $display("FAIL n1_des_isLast got %0b want 1", des8_isLast); end
      n_checks++; if (ser8_isLast !== 1'b1) begin n_fail++; $display("FAIL n1_ser_isLast got %0b want 1", ser8_isLast); end
      n_checks++; if (des8_canReceive !== 1'b1) begin n_fail++; $display("FAIL n1_des_canReceive got %0b want 1", des8_canReceive); end
      n_checks++; if (ser8_isReady !== 1'b0) begin n_fail++; $display("FAIL n1_ser_isReady got %0b want 0", ser8_isReady); end
      n_checks++; if (ser8 !== 8'h5A) begin n_fail++; $display("FAIL n1_ser got %h want 5a", ser8); end
      n_checks++; if (bw8 !== 8'hC3) begin n_fail++; $display("FAIL n1_buffer_write got %h want c3", bw8); end
      tick;
      c8_startDes = 0; des8 = 8'h00;
      #4;
      n_checks++; if (buf8_q !== 8'hC3) begin n_fail++; $display("FAIL n1_buffer got %h want c3", buf8_q); end
      n_checks++; if (c8_canReceive !== 1'b1) begin n_fail++; $display("FAIL n1_idle got %0b want 1", c8_canReceive); end
      n_checks++; if (des8_isLast !== 1'b0) begin n_fail++; $display("FAIL n1_no_extra_last got %0b want 0", des8_isLast); end
      tick;
      idle_inputs();
   endtask

   initial begin
      rst = 0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_abort();
      ld = 1; ld_val = {W3, W2, W1, W0};
      tick;
      ld = 0;
      test_des_full();
      test_ser_toggle();
      test_both();
      test_clamp();
      test_narrow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
